// File: rtl/arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port block memory with round-robin tie-break.
// Latency: request at cycle N -> memory issue at N+1 -> port ready at N+2 (minimum).
// Backpressure: one pending slot per port; a valid pulse on a busy, non-completing port is dropped.
module arbiter #(
  parameter bit INIT_DPRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  // data load/store port
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  // single-port memory side
  output logic        bram_valid,
  output logic        bram_instr,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_wstrb,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state_q;
  logic        owner_d_q;   // 1: dmem owns the current memory access
  logic        prio_d_q;    // 1: dmem wins the next tie
  logic        bram_valid_q, bram_instr_q;
  logic [31:0] bram_addr_q, bram_wdata_q;
  logic [3:0]  bram_wstrb_q;

  logic        pend_i_q, pend_i_d;
  logic        pend_d_q, pend_d_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] dwdata_q, dwdata_d;
  logic [3:0]  dwstrb_q, dwstrb_d;

  logic done, i_done, d_done, i_acc, d_acc, go, sel_d;

  // Completion, acceptance (set wins over clear) and next grant decision
  always_comb begin
    done     = (state_q == WAIT) && bram_ready;
    i_done   = done && !owner_d_q;
    d_done   = done && owner_d_q;
    i_acc    = imem_valid && (!pend_i_q || i_done);
    d_acc    = dmem_valid && (!pend_d_q || d_done);
    pend_i_d = i_acc || (pend_i_q && !i_done);
    pend_d_d = d_acc || (pend_d_q && !d_done);
    iaddr_d  = i_acc ? imem_addr  : iaddr_q;
    daddr_d  = d_acc ? dmem_addr  : daddr_q;
    dwdata_d = d_acc ? dmem_wdata : dwdata_q;
    dwstrb_d = d_acc ? dmem_wstrb : dwstrb_q;
    // Issue straight from the next-state pending view so a request never waits an extra cycle
    go       = ((state_q == IDLE) || done) && (pend_i_d || pend_d_d);
    sel_d    = pend_d_d && (!pend_i_d || prio_d_q);
  end

  // Per-port pending request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_i_q <= 1'b0;
      pend_d_q <= 1'b0;
      iaddr_q  <= '0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      dwstrb_q <= '0;
    end else begin
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
      iaddr_q  <= iaddr_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      dwstrb_q <= dwstrb_d;
    end
  end

  // Grant FSM with registered memory-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_d_q    <= 1'b0;
      prio_d_q     <= INIT_DPRIO;
      bram_valid_q <= 1'b0;
      bram_instr_q <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      bram_wstrb_q <= '0;
    end else begin
      bram_valid_q <= 1'b0;
      case (state_q)
        IDLE, WAIT: begin
          if (go) begin
            state_q      <= ISSUE;
            bram_valid_q <= 1'b1;
            owner_d_q    <= sel_d;
            prio_d_q     <= !sel_d;
            bram_instr_q <= !sel_d;
            bram_addr_q  <= sel_d ? daddr_d  : iaddr_d;
            bram_wdata_q <= sel_d ? dwdata_d : 32'h0;
            bram_wstrb_q <= sel_d ? dwstrb_d : 4'h0;
          end else if (done) begin
            state_q <= IDLE;
          end
        end
        ISSUE:   state_q <= WAIT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bram_valid = bram_valid_q;
  assign bram_instr = bram_instr_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;
  assign bram_wstrb = bram_wstrb_q;

  assign imem_ready = i_done;
  assign dmem_ready = d_done;
  assign imem_rdata = bram_rdata;
  assign dmem_rdata = bram_rdata;

endmodule

// File: tb/tb_arbiter.sv
module tb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_valid, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        bram_valid, bram_instr, bram_ready;
  logic [31:0] bram_addr, bram_wdata, bram_rdata;
  logic [3:0]  bram_wstrb;

  logic        mem_rdy = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        extra_rdy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {int cyc; logic instr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} iss_t;
  typedef struct {int cyc; logic is_d; logic [31:0] rdata;} cmp_t;
  iss_t iq[$];
  cmp_t rq[$];
  iss_t ie;
  cmp_t ce;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arbiter #(.INIT_DPRIO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .bram_valid(bram_valid), .bram_instr(bram_instr), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_wstrb(bram_wstrb), .bram_rdata(bram_rdata), .bram_ready(bram_ready)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory model: answers one cycle after sampling bram_valid
  always @(posedge clk) begin
    mem_rdy <= bram_valid;
    if (bram_valid) mem_rdata <= memword(bram_addr);
  end
  assign bram_ready = mem_rdy | extra_rdy;
  assign bram_rdata = extra_rdy ? 32'hBAD0_BAD0 : mem_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic exp_iss(input int c, input logic instr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    iss_t e;
    e.cyc = c; e.instr = instr; e.addr = a; e.wdata = wd; e.wstrb = ws;
    iq.push_back(e);
  endtask

  task automatic exp_cmp(input int c, input logic is_d, input logic [31:0] a);
    cmp_t e;
    e.cyc = c; e.is_d = is_d; e.rdata = memword(a);
    rq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((iq.size() != 0 || rq.size() != 0) && n < lim) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(iq.size() + rq.size()), 0);
    repeat (3) tick();
  endtask

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bram_valid) begin
      chk("issue_expected", (iq.size() != 0), 1);
      if (iq.size() != 0) begin
        ie = iq.pop_front();
        chk("issue_cycle", 64'(cyc), 64'(ie.cyc));
        chk("issue_instr", bram_instr, ie.instr);
        chk("issue_addr",  bram_addr,  ie.addr);
        chk("issue_wdata", bram_wdata, ie.wdata);
        chk("issue_wstrb", bram_wstrb, ie.wstrb);
      end
    end
    if (imem_ready || dmem_ready) begin
      chk("ready_onehot", (imem_ready && dmem_ready), 0);
      chk("ready_expected", (rq.size() != 0), 1);
      if (rq.size() != 0) begin
        ce = rq.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(ce.cyc));
        chk("ready_port",  dmem_ready, ce.is_d);
        chk("ready_rdata", dmem_ready ? dmem_rdata : imem_rdata, ce.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc;
    rst = 1'b1; extra_rdy = 1'b0;
    imem_valid = 0; imem_addr = '0;
    dmem_valid = 0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    repeat (2) tick();
    chk("rst_bram_valid", bram_valid, 0);
    chk("rst_bram_instr", bram_instr, 0);
    chk("rst_bram_addr",  bram_addr,  0);
    chk("rst_bram_wdata", bram_wdata, 0);
    chk("rst_bram_wstrb", bram_wstrb, 0);
    chk("rst_imem_ready", imem_ready, 0);
    chk("rst_dmem_ready", dmem_ready, 0);
    rst = 1'b0;
    tick();

    // Single fetch
    n = cyc;
    exp_iss(n + 1, 1, 32'h80, 0, 0); exp_cmp(n + 2, 0, 32'h80);
    imem_valid = 1; imem_addr = 32'h80;
    tick();
    imem_valid = 0;
    drain(20);

    // Simultaneous requests: dmem wins first tie
    n = cyc;
    exp_iss(n + 1, 0, 32'h200, 32'hDEAD_BEEF, 4'hF); exp_cmp(n + 2, 1, 32'h200);
    exp_iss(n + 3, 1, 32'h100, 0, 0);               exp_cmp(n + 4, 0, 32'h100);
    imem_valid = 1; imem_addr = 32'h100;
    dmem_valid = 1; dmem_addr = 32'h200; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
    tick();
    imem_valid = 0; dmem_valid = 0;
    drain(20);

    // Duplicate dmem pulse while busy is dropped
    n = cyc;
    exp_iss(n + 1, 0, 32'h10, 32'h1111_1111, 4'h0); exp_cmp(n + 2, 1, 32'h10);
    dmem_valid = 1; dmem_addr = 32'h10; dmem_wdata = 32'h1111_1111; dmem_wstrb = 4'h0;
    tick();
    dmem_addr = 32'h20; dmem_wdata = 32'h2222_2222;
    tick();
    dmem_valid = 0;
    drain(20);
    repeat (4) tick();

    // Fairness: both ports request continuously; last grant was dmem so imem leads
    n = cyc;
    for (int k = 0; k < 20; k++) begin
      acc = (k < 2) ? 0 : 2 * k - 2;
      if (k % 2 == 0) begin
        exp_iss(n + 1 + 2 * k, 1, 32'h1000 + 32'(4 * acc), 0, 0);
        exp_cmp(n + 2 + 2 * k, 0, 32'h1000 + 32'(4 * acc));
      end else begin
        exp_iss(n + 1 + 2 * k, 0, 32'h2000 + 32'(4 * acc), 32'hC0DE_0000 + 32'(acc), 4'(acc));
        exp_cmp(n + 2 + 2 * k, 1, 32'h2000 + 32'(4 * acc));
      end
    end
    for (int off = 0; off <= 36; off++) begin
      imem_valid = 1; imem_addr = 32'h1000 + 32'(4 * off);
      dmem_valid = 1; dmem_addr = 32'h2000 + 32'(4 * off);
      dmem_wdata = 32'hC0DE_0000 + 32'(off); dmem_wstrb = 4'(off);
      tick();
    end
    imem_valid = 0; dmem_valid = 0;
    drain(40);

    // Reset during dmem WAIT
    n = cyc;
    exp_iss(n + 1, 0, 32'h300, 32'h0, 4'h0);
    dmem_valid = 1; dmem_addr = 32'h300; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
    tick();
    dmem_valid = 0;
    tick();
    rst = 1'b1;
    #1;
    chk("wait_rst_dmem_ready", dmem_ready, 0);
    chk("wait_rst_bram_valid", bram_valid, 0);
    chk("wait_rst_bram_addr",  bram_addr,  0);
    tick();
    rst = 1'b0; extra_rdy = 1'b1;
    #1;
    chk("post_rst_imem_ready", imem_ready, 0);
    chk("post_rst_dmem_ready", dmem_ready, 0);
    tick();
    extra_rdy = 1'b0;
    chk("post_rst_queue", 64'(iq.size() + rq.size()), 0);

    // Tie priority restored by reset
    n = cyc;
    exp_iss(n + 1, 0, 32'h500, 32'hA5A5_0001, 4'h3); exp_cmp(n + 2, 1, 32'h500);
    exp_iss(n + 3, 1, 32'h400, 0, 0);               exp_cmp(n + 4, 0, 32'h400);
    imem_valid = 1; imem_addr = 32'h400;
    dmem_valid = 1; dmem_addr = 32'h500; dmem_wdata = 32'hA5A5_0001; dmem_wstrb = 4'h3;
    tick();
    imem_valid = 0; dmem_valid = 0;
    drain(20);

    // Plain fetch after reset, 2-cycle latency
    n = cyc;
    exp_iss(n + 1, 1, 32'h80, 0, 0); exp_cmp(n + 2, 0, 32'h80);
    imem_valid = 1; imem_addr = 32'h80;
    tick();
    imem_valid = 0;
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 SHALL have parameter INIT_DPRIO, default 1, meaning dmem port wins the first tie after reset (0: imem wins).
REQ-002 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port imem_valid  input  1  one-cycle instruction-fetch request pulse.
REQ-005 SHALL have port imem_addr  input  32  fetch byte address.
REQ-006 SHALL have port imem_rdata  output  32  fetch read data.
REQ-007 SHALL have port imem_ready  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port dmem_valid  input  1  one-cycle load/store request pulse.
REQ-009 SHALL have port dmem_addr  input  32  data byte address.
REQ-010 SHALL have port dmem_wdata  input  32  store data.
REQ-011 SHALL have port dmem_wstrb  input  4  byte write strobes; 0 = load.
REQ-012 SHALL have port dmem_rdata  output  32  load read data.
REQ-013 SHALL have port dmem_ready  output  1  one-cycle data completion pulse.
REQ-014 SHALL have ports bram_valid/bram_instr (1), bram_addr/bram_wdata (32), bram_wstrb (4) as outputs and bram_rdata (32)/bram_ready (1) as inputs, driving a single-port memory that returns bram_ready one cycle after sampling bram_valid.

Function
REQ-015 SHALL capture each port request (addr, wdata, wstrb) into a per-port pending register on the posedge where its valid=1.
REQ-016 SHALL ignore a valid pulse on a port whose pending request is outstanding and not completing that cycle; pending contents unchanged.
REQ-017 SHALL accept a new request on a port in the same cycle that port's ready is asserted (set wins over clear).
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT; IDLE: no grant; ISSUE: bram_valid=1 for exactly one cycle; WAIT: bram_valid=0 until bram_ready=1.
REQ-019 SHALL leave IDLE for ISSUE on the posedge after any pending bit is set, i.e. request at cycle N gives bram_valid at N+1 and port ready at N+2 minimum.
REQ-020 SHALL, in WAIT with bram_ready=1, pulse the owner's ready combinationally with rdata=bram_rdata, clear its pending bit, and go to ISSUE if any pending remains (back-to-back), else IDLE.
REQ-021 SHALL hold imem_ready=0/dmem_ready=0 whenever not the completing owner; rdata outputs may follow bram_rdata freely.
REQ-022 SHALL drive bram_instr=1, bram_wstrb=0, bram_wdata=0 for imem grants; bram_instr=0 and pending wstrb/wdata for dmem grants; bram_addr from the granted pending register.
REQ-023 SHALL, when both pending at grant, select the port not granted last (round-robin); first tie after reset follows INIT_DPRIO.
REQ-024 SHALL register all bram_* outputs; they are stable for the whole ISSUE cycle.
REQ-025 SHALL ignore bram_ready outside WAIT.

Reset
REQ-026 SHALL on rst=1 immediately force state IDLE, both pending bits 0, bram_valid=0, bram_instr=0, bram_addr/wdata=0, bram_wstrb=0, imem_ready=dmem_ready=0, last-grant per INIT_DPRIO.
REQ-027 SHALL discard any in-flight request on reset; a bram_ready arriving in the first cycle after reset release is ignored.

Verification
REQ-028 SHALL test single fetch: imem_valid, addr 0x80 at N -> bram_valid,bram_instr=1,addr 0x80 at N+1 -> imem_ready, imem_rdata=memory word at N+2.
REQ-029 SHALL test simultaneous imem 0x100 and dmem store 0x200/wdata 0xDEADBEEF/wstrb 0xF at N with INIT_DPRIO=1 -> dmem issued N+1, dmem_ready N+2, imem issued N+3, imem_ready N+4.
REQ-030 SHALL test fairness: both ports re-request continuously -> grants alternate I/D every 2 cycles, no starvation over 20 requests.
REQ-031 SHALL test duplicate: dmem_valid at N and N+1 (addr 0x10 then 0x20) -> only 0x10 issued, single dmem_ready.
REQ-032 SHALL test reset in WAIT: rst pulsed during dmem WAIT -> no dmem_ready, bram_valid=0, next imem request served normally with 2-cycle latency.
